alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-client arbiter and pipeline wrapper that shares the single 32-bit `main_alu` between the execute stage (client 0) and the branch/address unit (client 1). Requests arrive on valid/ready handshakes. Grants alternate round-robin under contention. Each accepted operation is registered into the ALU, and the result plus zero flag return to the issuing client exactly two cycles after acceptance. The block sustains one operation per cycle and keeps saturating per-client issue counters for performance monitoring.

## Interface

**Parameters**

- `WIDTH`, default 32: datapath width. Must match `main_alu`.
- `CNT_W`, default 16: width of each per-client issue counter.

**Ports**

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, **asynchronous, active-low**.
- `req_valid_0` / `req_valid_1` input 1: client request valid.
- `req_ready_0` / `req_ready_1` output 1: grant. The transfer happens when valid && ready at a rising edge.
- `req_a_0`, `req_b_0`, `req_a_1`, `req_b_1` input WIDTH: operands.
- `req_op_0` / `req_op_1` input 2: ALU operation. 00 = XNOR, 01 = ADD, 10 = AND, 11 = SUB.
- `resp_valid_0` / `resp_valid_1` output 1: one-cycle response strobe. There is no backpressure on the response.
- `resp_result` output WIDTH: registered ALU result, shared by both clients and qualified by the strobes.
- `resp_zero` output 1: registered zero flag; 1 when the result is 0.
- `issue_cnt_0` / `issue_cnt_1` output CNT_W: accepted-operation counters, saturating.

## Operation

- **Arbitration**
  - Grants are combinational from valid and the round-robin pointer `rr`, a 1-bit register.
  - `req_ready_x` = `req_valid_x` && (other client not valid || `rr` == x).
  - At most one ready is high in any cycle. Ready is never high without the matching valid.
  - `rr` updates only on a grant: `rr` <= ~(granted client id). With no grant, `rr` holds.
- **Stage 1 (issue register)**
  - On a grant, capture the granted a, b, op and client id into s1 registers, and set `s1_valid` = 1.
  - With no grant, `s1_valid` = 0 and the data registers hold.
- **ALU**
  - The s1 registers drive `main_alu` combinationally.
  - Arithmetic is modulo 2^WIDTH. Carry and borrow are discarded.
  - SUB is a − b, so 0 − 1 = 0xFFFF_FFFF.
- **Stage 2 (response register)**
  - `resp_result`, `resp_zero` and the s2 client id are captured from the ALU when `s1_valid` = 1; otherwise they hold.
  - `resp_valid_x` = s2_valid && (s2_id == x).
- **Counters**
  - `issue_cnt_x` increments on each grant to client x.
  - It saturates at 2^CNT_W − 1 and never wraps.
- A client that is not granted must hold valid and its operands stable until ready is observed. The block does not latch ungranted requests.

## Timing

- **Reset values** (asynchronous assert, synchronous-safe deassert by the system):
  - `rr` = 0 (client 0 wins first contention).
  - s1/s2 valid = 0, so both `resp_valid` = 0.
  - `resp_result` = 0, `resp_zero` = 1 (consistent with result 0).
  - Both counters = 0.
  - Both readies = 0 while `rst_n` = 0.
- **Latency**
  - Request accepted at edge E0: the result is captured at E1, and `resp_valid_x` is high for exactly the cycle between E1 and E2.
  - A single uncontended request asserted before E0 therefore sees its response in the 2nd cycle after acceptance.
- **Throughput:** one grant per cycle. Back-to-back grants produce back-to-back response strobes in the same order.
- **Contention**
  - If both clients are continuously valid, grants alternate 0,1,0,1…
  - If only one client is valid, it is granted every cycle.
- **Reset mid-operation:** operations in s1/s2 are discarded with no response strobe, and counters clear.
- **Response strobes:** exactly one, or zero, `resp_valid` is high per cycle.

## Structure

- **Shared package `alu_pkg`:**
  - op encodings `ALU_XNOR` = 2'b00, `ALU_ADD` = 2'b01, `ALU_AND` = 2'b10, `ALU_SUB` = 2'b11;
  - client id constants `CLI_EX` = 0, `CLI_BR` = 1;
  - default `WIDTH` = 32.
- **Sub-module:** one instance of the existing `main_alu`, with ports a, b, ALU_op, result, zero. Its zero output feeds the stage-2 register directly.
- **Local logic:** the arbiter stays inline (a few lines). No separate arbiter module.

## Test plan

1. **Reset.**
   - Stimulus: hold `rst_n` = 0 with both valids high.
   - Required: readies 0, resp_valids 0, `resp_result` 0, `resp_zero` 1, counters 0.
2. **Single request.**
   - Stimulus: client 0 sends ADD a=5, b=7.
   - Required: ready in the same cycle; `resp_valid_0` exactly 2 cycles after the accept edge, with `resp_result` = 12 and `resp_zero` = 0; `issue_cnt_0` = 1.
3. **Contention.**
   - Stimulus: both clients held valid for 4 cycles. Client 0 sends SUB 9,9; client 1 sends AND 0xF0,0x0F.
   - Required: grant order 0,1,0,1. Client 0 responses give result 0 with zero = 1. Client 1 responses give 0 with zero = 1. The strobes alternate.
4. **Wraparound and XNOR.**
   - Stimulus: client 1 sends SUB 0,1, then ADD 0xFFFF_FFFF,1, then XNOR 0,0.
   - Required: results 0xFFFF_FFFF (zero 0), 0 (zero 1), 0xFFFF_FFFF (zero 0), on consecutive cycles.
5. **Mid-flight reset.**
   - Stimulus: assert `rst_n` = 0 one cycle after a grant.
   - Required: no `resp_valid` ever for that operation; all registers at their reset values.
6. **Counter saturation.**
   - Setup: `CNT_W` = 4.
   - Stimulus: 20 grants to client 0.
   - Required: `issue_cnt_0` stops at 15; `issue_cnt_1` remains 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: op encodings, client ids, default width.
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ALU_XNOR = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_SUB  = 2'b11
  } alu_op_e;

  localparam logic CLI_EX = 1'b0;
  localparam logic CLI_BR = 1'b1;

endpackage

// File: rtl/main_alu.sv
// Combinational 32-bit ALU shared by the execute stage and the branch/address unit.
module main_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ALU_op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Operation select; carry and borrow fall off the top (modulo 2^WIDTH).
  always_comb begin
    result = '0;
    case (alu_op_e'(ALU_op))
      ALU_XNOR: result = ~(a ^ b);
      ALU_ADD:  result = a + b;
      ALU_AND:  result = a & b;
      ALU_SUB:  result = a - b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter plus two-stage pipeline sharing main_alu between two clients.
// A grant at edge E0 registers the operands; the ALU result is captured at E1 and
// strobed to the issuing client for the single cycle E1..E2.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [1:0]       req_op_0,
  input  logic [1:0]       req_op_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [CNT_W-1:0] issue_cnt_0,
  output logic [CNT_W-1:0] issue_cnt_1
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rr;
  logic             gnt;
  logic             gnt_id;
  logic             s1_valid;
  logic             s1_id;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;
  logic             s2_valid;
  logic             s2_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // Readies are forced low during reset so nothing can look granted while rr is being cleared.
  assign req_ready_0 = rst_n && req_valid_0 && (!req_valid_1 || rr == CLI_EX);
  assign req_ready_1 = rst_n && req_valid_1 && (!req_valid_0 || rr == CLI_BR);
  assign gnt         = req_ready_0 || req_ready_1;
  assign gnt_id      = req_ready_1;

  // Round-robin pointer: after a grant, the other client has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= CLI_EX;
    end else if (gnt) begin
      rr <= ~gnt_id;
    end
  end

  // Issue register: capture the granted operation; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= CLI_EX;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      s1_valid <= gnt;
      if (gnt) begin
        s1_id <= gnt_id;
        s1_a  <= gnt_id ? req_a_1  : req_a_0;
        s1_b  <= gnt_id ? req_b_1  : req_b_0;
        s1_op <= gnt_id ? req_op_1 : req_op_0;
      end
    end
  end

  main_alu #(
    .WIDTH (WIDTH)
  ) u_main_alu (
    .a      (s1_a),
    .b      (s1_b),
    .ALU_op (s1_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Response register: result and zero flag captured from the ALU when stage 1 holds an op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_id       <= CLI_EX;
      resp_result <= '0;
      resp_zero   <= 1'b1;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id       <= s1_id;
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
      end
    end
  end

  assign resp_valid_0 = s2_valid && (s2_id == CLI_EX);
  assign resp_valid_1 = s2_valid && (s2_id == CLI_BR);

  // Per-client issue counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_0 <= '0;
      issue_cnt_1 <= '0;
    end else begin
      if (req_ready_0 && issue_cnt_0 != CNT_MAX) issue_cnt_0 <= issue_cnt_0 + CNT_ONE;
      if (req_ready_1 && issue_cnt_1 != CNT_MAX) issue_cnt_1 <= issue_cnt_1 + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized plus directed bench for alu_share_arb with a queue-based scoreboard.
module tb_alu_share_arb;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_0, req_valid_1;
  logic          req_ready_0, req_ready_1;
  logic [W-1:0]  req_a_0, req_b_0, req_a_1, req_b_1;
  logic [1:0]    req_op_0, req_op_1;
  logic          resp_valid_0, resp_valid_1;
  logic [W-1:0]  resp_result;
  logic          resp_zero;
  logic [CW-1:0] issue_cnt_0, issue_cnt_1;

  alu_share_arb #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_0  (req_valid_0),
    .req_valid_1  (req_valid_1),
    .req_ready_0  (req_ready_0),
    .req_ready_1  (req_ready_1),
    .req_a_0      (req_a_0),
    .req_b_0      (req_b_0),
    .req_a_1      (req_a_1),
    .req_b_1      (req_b_1),
    .req_op_0     (req_op_0),
    .req_op_1     (req_op_1),
    .resp_valid_0 (resp_valid_0),
    .resp_valid_1 (resp_valid_1),
    .resp_result  (resp_result),
    .resp_zero    (resp_zero),
    .issue_cnt_0  (issue_cnt_0),
    .issue_cnt_1  (issue_cnt_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         id;
    logic [W-1:0] res;
    bit         zero;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  bit   done = 1'b0;
  bit   done_checked = 1'b0;

  // reference model state
  int   last_winner = 1;
  int   mcnt0 = 0;
  int   mcnt1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned m, r;
    m = 64'd1 << W;
    case (op)
      2'd0:    r = ~(longint'(a) ^ longint'(b)) & (m - 1);
      2'd1:    r = (longint'(a) + longint'(b)) % m;
      2'd2:    r = longint'(a) & longint'(b);
      default: r = (longint'(a) + m - longint'(b)) % m;
    endcase
    return W'(r);
  endfunction

  // Model: predicts grants and counters, pushes expected responses.
  always @(negedge clk) begin
    bit e0, e1;
    exp_t e;
    if (!rst_n) begin
      last_winner = 1;
      mcnt0 = 0;
      mcnt1 = 0;
    end else begin
      e0 = req_valid_0 && (!req_valid_1 || last_winner == 1);
      e1 = req_valid_1 && (!req_valid_0 || last_winner == 0);
      chk("ready", {req_ready_0, req_ready_1}, {e0, e1});
      chk("issue_cnt", {issue_cnt_0, issue_cnt_1}, {CW'(mcnt0), CW'(mcnt1)});
      if (e0 || e1) begin
        e.due  = cyc + 2;
        e.id   = e1;
        e.res  = e1 ? ref_alu(req_op_1, req_a_1, req_b_1) : ref_alu(req_op_0, req_a_0, req_b_0);
        e.zero = (e.res == 0);
        exp_q.push_back(e);
        last_winner = e1 ? 1 : 0;
        if (e0) mcnt0 = (mcnt0 < (1 << CW) - 1) ? mcnt0 + 1 : mcnt0;
        if (e1) mcnt1 = (mcnt1 < (1 << CW) - 1) ? mcnt1 + 1 : mcnt1;
      end
    end
  end

  // Monitor: checks reset state, and pops/compares whenever a response strobe appears.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      chk("reset_state",
          {req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_result, resp_zero, issue_cnt_0, issue_cnt_1},
          {4'b0000, 32'h0, 1'b1, 8'h00});
    end else begin
      if (resp_valid_0 || resp_valid_1) begin
        if (resp_valid_0 && resp_valid_1) chk("one_strobe", 1, 0);
        if (exp_q.size() == 0) begin
          chk("spurious_resp", {resp_valid_0, resp_valid_1}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("resp_latency", cyc, e.due);
          chk("resp_client", {resp_valid_0, resp_valid_1}, {!e.id, e.id});
          chk("resp_result", resp_result, e.res);
          chk("resp_zero", resp_zero, e.zero);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_resp", 0, 1);
      end
    end
    if (done && !done_checked) begin
      done_checked = 1'b1;
      chk("queue_drained", exp_q.size(), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input bit v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid_0 = v; req_op_0 = op; req_a_0 = a; req_b_0 = b;
  endtask

  task automatic set1(input bit v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid_1 = v; req_op_1 = op; req_a_1 = a; req_b_1 = b;
  endtask

  task automatic rand_ops(output logic [1:0] op, output logic [W-1:0] a, output logic [W-1:0] b);
    int sel;
    op  = 2'($urandom_range(0, 3));
    sel = $urandom_range(0, 3);
    a   = (sel == 3) ? '0 : W'($urandom);
    b   = (sel == 0) ? a : (sel == 1) ? W'(1) : W'($urandom);
  endtask

  initial begin
    bit g0, g1;
    logic [1:0] op;
    logic [W-1:0] a, b;

    // reset with both clients requesting
    rst_n = 1'b0;
    set0(1, 2'b01, 32'd1, 32'd2);
    set1(1, 2'b01, 32'd3, 32'd4);
    repeat (3) step();
    rst_n = 1'b1;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step();

    // single ADD 5+7 from client 0
    set0(1, 2'b01, 32'd5, 32'd7);
    step();
    set0(0, 0, 0, 0);
    repeat (3) step();

    // contention: both valid for 4 cycles
    set0(1, 2'b11, 32'd9, 32'd9);
    set1(1, 2'b10, 32'hF0, 32'h0F);
    repeat (4) step();
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    repeat (3) step();

    // wraparound and XNOR on client 1, back to back
    set1(1, 2'b11, 32'h0, 32'h1);
    step();
    set1(1, 2'b01, 32'hFFFF_FFFF, 32'h1);
    step();
    set1(1, 2'b00, 32'h0, 32'h0);
    step();
    set1(0, 0, 0, 0);
    repeat (3) step();

    // reset one cycle after a grant
    set0(1, 2'b01, 32'd1, 32'd1);
    step();
    set0(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();

    // random traffic; ungranted requests hold their operands
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      g0 = req_ready_0;
      g1 = req_ready_1;
      @(posedge clk);
      #1;
      if (!(req_valid_0 && !g0)) begin
        rand_ops(op, a, b);
        set0($urandom_range(0, 99) < 60, op, a, b);
      end
      if (!(req_valid_1 && !g1)) begin
        rand_ops(op, a, b);
        set1($urandom_range(0, 99) < 60, op, a, b);
      end
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    repeat (3) step();

    // counter saturation: fresh reset then 20 grants to client 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      set0(1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      step();
    end
    set0(0, 0, 0, 0);
    repeat (4) step();

    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
